chip8_keypad_scanner: RTL and testbench

- Upstream input stage for the chip8 core. Scans a 4x4 hex matrix keypad, synchronises and debounces it, and produces the core's `input_keys` bitmap.
- Also produces the latched `newest_key_down` code, which the core consumes for Fx0A (wait for key) and releases via `clear_newest_key_down`.
- Runs on the core's clock domain, so no CDC is needed on the outputs.

---
 rtl/chip8_keypad_scanner_if.sv | 25 ++
 rtl/chip8_keypad_scanner.sv | 141 ++++++++++++++
 tb/tb_chip8_keypad_scanner.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/chip8_keypad_scanner_if.sv
// Signal bundle between the chip8 keypad scanner, the 4x4 key matrix and the core.
// The scanner takes the slave view; the matrix/core side takes the master view.
interface chip8_keypad_scanner_if;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic        clear_newest_key_down;
    logic [15:0] input_keys;
    logic [4:0]  newest_key_down;

    modport slave (
        input  row_n,
        input  clear_newest_key_down,
        output col_n,
        output input_keys,
        output newest_key_down
    );

    modport master (
        output row_n,
        output clear_newest_key_down,
        input  col_n,
        input  input_keys,
        input  newest_key_down
    );
endinterface

// File: rtl/chip8_keypad_scanner.sv
// 4x4 hex keypad scanner: column drive, row synchroniser, per-key debounce,
// and the latched newest-key code consumed by the chip8 core's Fx0A.
module chip8_keypad_scanner #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    chip8_keypad_scanner_if.slave bus
);
    localparam int                SLOT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int                CNT_MIN   = $clog2(DEBOUNCE_FRAMES + 1);
    localparam int                CNT_W     = (CNT_MIN > 3) ? CNT_MIN : 3;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_FLIP  = CNT_W'(DEBOUNCE_FRAMES - 1);
    localparam logic [4:0]        NO_KEY    = 5'd16;

    logic [3:0]        r_row_meta;
    logic [3:0]        r_row_sync;
    logic [SLOT_W-1:0] r_slot;
    logic [1:0]        r_col;
    logic [3:0]        r_col_n;
    logic [CNT_W-1:0]  r_db_cnt [16];
    logic [15:0]       r_keys;
    logic [4:0]        r_newest;

    logic              w_sample;
    logic [CNT_W-1:0]  w_db_cnt_nxt [16];
    logic [15:0]       w_keys_nxt;
    logic [4:0]        w_newest_nxt;

    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        code = 4'h0;
        case ({row, col})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hC;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hD;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hE;
            4'b11_00: code = 4'hA;
            4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hB;
            4'b11_11: code = 4'hF;
            default:  code = 4'h0;
        endcase
        return code;
    endfunction

    // NOTE: the synchroniser resets to "no row pulled low" so nothing looks pressed out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_meta <= 4'hF;
            r_row_sync <= 4'hF;
        end else begin
            r_row_meta <= bus.row_n;
            r_row_sync <= r_row_meta;
        end
    end

    assign w_sample = (r_slot == SLOT_LAST);

    // Column drive is kept as its own one-hot register so col_n never glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot  <= '0;
            r_col   <= 2'd0;
            r_col_n <= 4'b1110;
        end else if (w_sample) begin
            r_slot  <= '0;
            r_col   <= r_col + 2'd1;
            r_col_n <= {r_col_n[2:0], r_col_n[3]};
        end else begin
            r_slot  <= r_slot + 1'b1;
        end
    end

    // NOTE: combinational next-state uses blocking assignments, with every output defaulted first.
    always_comb begin
        logic [3:0] k_idx;
        logic       raw;
        k_idx        = 4'h0;
        raw          = 1'b0;
        w_keys_nxt   = r_keys;
        w_newest_nxt = r_newest;
        for (int k = 0; k < 16; k++) begin
            w_db_cnt_nxt[k] = r_db_cnt[k];
        end

        if (bus.clear_newest_key_down) begin
            w_newest_nxt = NO_KEY;
        end

        // Rows are visited high to low so the lowest simultaneous riser is written last and wins.
        if (w_sample) begin
            for (int r = 3; r >= 0; r--) begin
                k_idx = key_code(2'(r), r_col);
                raw   = ~r_row_sync[r];
                if (raw == r_keys[k_idx]) begin
                    w_db_cnt_nxt[k_idx] = '0;
                end else if (r_db_cnt[k_idx] == CNT_FLIP) begin
                    w_db_cnt_nxt[k_idx] = '0;
                    w_keys_nxt[k_idx]   = raw;
                    if (raw) begin
                        w_newest_nxt = {1'b0, k_idx};
                    end
                end else begin
                    w_db_cnt_nxt[k_idx] = r_db_cnt[k_idx] + 1'b1;
                end
            end
        end
    end

    // NOTE: the debounce counters are a flop array with reset, not a memory, so they can be cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 16; k++) begin
                r_db_cnt[k] <= '0;
            end
            r_keys   <= '0;
            r_newest <= NO_KEY;
        end else begin
            for (int k = 0; k < 16; k++) begin
                r_db_cnt[k] <= w_db_cnt_nxt[k];
            end
            r_keys   <= w_keys_nxt;
            r_newest <= w_newest_nxt;
        end
    end

    assign bus.col_n           = r_col_n;
    assign bus.input_keys      = r_keys;
    assign bus.newest_key_down = r_newest;
endmodule

// File: tb/tb_chip8_keypad_scanner.sv
// Bench for chip8_keypad_scanner: modelled key matrix, directed vector table,
// mid-scan reset sequence and a randomised run against a sample-history model.
module tb_chip8_keypad_scanner;
    localparam int SD = 4;
    localparam int DF = 2;
    localparam int KEYMAP [4][4] = '{'{1, 2, 3, 12}, '{4, 5, 6, 13}, '{7, 8, 9, 14}, '{10, 0, 11, 15}};

    logic        clk;
    logic        clk_en;
    logic        rst_n;
    logic        clear;
    logic [15:0] pressed;
    logic [3:0]  w_row_n;
    int          edge_n;
    int          clr_edge;
    int          checks;
    int          failures;

    chip8_keypad_scanner_if kp ();

    chip8_keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (kp.slave)
    );

    initial clk = 1'b0;
    always #5 if (clk_en) clk = ~clk;

    // Matrix: a row reads low when a held key sits on it in a driven column.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            w_row_n[r] = 1'b1;
            for (int c = 0; c < 4; c++) begin
                if (!kp.col_n[c] && pressed[KEYMAP[r][c]]) w_row_n[r] = 1'b0;
            end
        end
    end
    assign kp.row_n                 = w_row_n;
    assign kp.clear_newest_key_down = clear;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_n <= 0;
        else        edge_n <= edge_n + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic goto_edge(input int n);
        int guard;
        guard = 0;
        while (edge_n < n && guard < 2000) begin
            @(negedge clk);
            if (edge_n > clr_edge) clear = 1'b0;
            guard++;
        end
    endtask

    // Reference model: a key flips once its last DF column samples all disagree with its state.
    logic [15:0] m_keys;
    logic [4:0]  m_newest;
    int          m_hist [16];
    logic [15:0] m_seen1, m_seen2;
    int          m_cyc;

    task automatic model_reset();
        m_keys   = '0;
        m_newest = 5'd16;
        for (int k = 0; k < 16; k++) m_hist[k] = 0;
        m_seen1  = '0;
        m_seen2  = '0;
        m_cyc    = 0;
    endtask

    // Called just before each rising edge; the sampled row value is two edges old (synchroniser).
    task automatic model_step();
        logic [15:0] seen;
        int          col, k, mask;
        logic        done;
        seen    = m_seen2;
        m_seen2 = m_seen1;
        m_seen1 = pressed;
        mask    = (1 << DF) - 1;
        done    = 1'b0;
        if (clear) m_newest = 5'd16;
        if (m_cyc % SD == SD - 1) begin
            col = (m_cyc / SD) % 4;
            for (int r = 0; r < 4; r++) begin
                k = KEYMAP[r][col];
                m_hist[k] = ((m_hist[k] << 1) | int'(seen[k])) & mask;
                if (m_hist[k] == (m_keys[k] ? 0 : mask)) begin
                    m_keys[k] = ~m_keys[k];
                    if (m_keys[k] && !done) begin
                        m_newest = 5'(k);
                        done     = 1'b1;
                    end
                end
            end
        end
        m_cyc++;
    endtask

    typedef struct {
        string       name;
        int          at_edge;
        logic [15:0] set_press;
        logic        set_clr;
        logic [15:0] exp_keys;
        logic [4:0]  exp_newest;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input string n, input int e, input logic [15:0] p, input logic c,
                           input logic [15:0] ek, input logic [4:0] en);
        vec_t v;
        v.name = n; v.at_edge = e; v.set_press = p; v.set_clr = c;
        v.exp_keys = ek; v.exp_newest = en;
        vecs.push_back(v);
    endtask

    initial begin
        logic [3:0] exp_col;
        checks   = 0;
        failures = 0;
        clk_en   = 1'b0;
        rst_n    = 1'b1;
        clear    = 1'b0;
        pressed  = 16'h0020;
        clr_edge = -10;

        add_vec("press_pre",        23,  16'h0020, 1'b0, 16'h0000, 5'd16);
        add_vec("press_hit",        24,  16'h0000, 1'b0, 16'h0020, 5'd5);
        add_vec("release_pre",      55,  16'h0000, 1'b0, 16'h0020, 5'd5);
        add_vec("release_hit",      56,  16'h0000, 1'b1, 16'h0000, 5'd5);
        add_vec("clear_newest",     57,  16'h0000, 1'b0, 16'h0000, 5'd16);
        add_vec("bounce_start",     60,  16'h0400, 1'b0, 16'h0000, 5'd16);
        add_vec("bounce_drop",      70,  16'h0000, 1'b0, 16'h0000, 5'd16);
        add_vec("bounce_gap",       100, 16'h0400, 1'b0, 16'h0000, 5'd16);
        add_vec("bounce_again",     118, 16'h0000, 1'b0, 16'h0000, 5'd16);
        add_vec("bounce_end",       133, 16'h0082, 1'b0, 16'h0000, 5'd16);
        add_vec("multi_pre",        163, 16'h0082, 1'b0, 16'h0000, 5'd16);
        add_vec("multi_hit",        164, 16'h8082, 1'b0, 16'h0082, 5'd1);
        add_vec("f_pre",            191, 16'h8082, 1'b0, 16'h0082, 5'd1);
        add_vec("f_hit",            192, 16'h8082, 1'b1, 16'h8082, 5'd15);
        add_vec("clear_keys_kept",  193, 16'h8282, 1'b0, 16'h8082, 5'd16);
        add_vec("clr_press_pre",    219, 16'h8282, 1'b1, 16'h8082, 5'd16);
        add_vec("clr_press_hit",    220, 16'h0282, 1'b0, 16'h8282, 5'd9);
        add_vec("release_keeps_nk", 240, 16'h0283, 1'b0, 16'h0282, 5'd9);

        // Reset with the clock stopped.
        #2 rst_n = 1'b0;
        #1;
        check("rst_col_n", 32'(kp.col_n), 32'h0000_000E);
        check("rst_keys", 32'(kp.input_keys), 32'h0);
        check("rst_newest", 32'(kp.newest_key_down), 32'd16);
        clk_en = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k <= 16; k++) begin
            goto_edge(k);
            exp_col = ~(4'b0001 << ((k / SD) % 4));
            check("col_seq", 32'(kp.col_n), 32'(exp_col));
        end

        foreach (vecs[i]) begin
            goto_edge(vecs[i].at_edge);
            check({vecs[i].name, "_keys"}, 32'(kp.input_keys), 32'(vecs[i].exp_keys));
            check({vecs[i].name, "_newest"}, 32'(kp.newest_key_down), 32'(vecs[i].exp_newest));
            pressed = vecs[i].set_press;
            if (vecs[i].set_clr) begin
                clear    = 1'b1;
                clr_edge = edge_n;
            end
        end

        // Reset in the middle of a column-2 slot with key 0 part-way through debouncing.
        goto_edge(249);
        check("mid_col2", 32'(kp.col_n), 32'h0000_000B);
        #2 rst_n = 1'b0;
        clear    = 1'b0;
        clr_edge = -10;
        #1;
        check("mid_rst_col_n", 32'(kp.col_n), 32'h0000_000E);
        check("mid_rst_keys", 32'(kp.input_keys), 32'h0);
        check("mid_rst_newest", 32'(kp.newest_key_down), 32'd16);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        goto_edge(19);
        check("rearm_pre_keys", 32'(kp.input_keys), 32'h0);
        check("rearm_pre_newest", 32'(kp.newest_key_down), 32'd16);
        goto_edge(20);
        check("rearm_c0_keys", 32'(kp.input_keys), 32'h0082);
        check("rearm_c0_newest", 32'(kp.newest_key_down), 32'd1);
        goto_edge(24);
        check("rearm_c1_keys", 32'(kp.input_keys), 32'h0083);
        check("rearm_c1_newest", 32'(kp.newest_key_down), 32'd0);
        goto_edge(28);
        check("rearm_c2_keys", 32'(kp.input_keys), 32'h0283);
        check("rearm_c2_newest", 32'(kp.newest_key_down), 32'd9);

        // Randomised run against the reference model, with one reset part-way through.
        rst_n   = 1'b0;
        clear   = 1'b0;
        pressed = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc == 2000) begin
                rst_n = 1'b0;
                model_reset();
                #1;
                check("rand_rst_keys", 32'(kp.input_keys), 32'(m_keys));
                check("rand_rst_newest", 32'(kp.newest_key_down), 32'(m_newest));
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
            end
            if ($urandom_range(0, 9) == 0) pressed[$urandom_range(0, 15)] ^= 1'b1;
            clear = ($urandom_range(0, 15) == 0);
            model_step();
            @(negedge clk);
            exp_col = ~(4'b0001 << ((m_cyc / SD) % 4));
            check("rand_col_n", 32'(kp.col_n), 32'(exp_col));
            check("rand_keys", 32'(kp.input_keys), 32'(m_keys));
            check("rand_newest", 32'(kp.newest_key_down), 32'(m_newest));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
